// File: rtl/spec_top_fmc_adc_100ms.sv
// Multi-shot ADC acquisition controller: register bank, trigger FSM and sample stream to memory.
// Define FMC_ADC_THRES_TRIG_EN to build the per-channel threshold triggers with hysteresis.
module spec_top_fmc_adc_100ms #(
  parameter int G_CHANNELS = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [5:0]                reg_addr_i,
  input  logic [31:0]               reg_wdata_i,
  input  logic                      reg_we_i,
  input  logic                      reg_stb_i,
  output logic                      reg_ack_o,
  output logic [31:0]               reg_rdata_o,
  input  logic                      smp_valid_i,
  input  logic [16*G_CHANNELS-1:0]  smp_data_i,
  input  logic                      ext_trig_i,
  input  logic                      time_trig_i,
  output logic                      wr_valid_o,
  output logic [16*G_CHANNELS-1:0]  wr_data_o,
  output logic [23:0]               wr_addr_o,
  output logic                      trig_o,
  output logic                      acq_end_o,
  output logic [2:0]                acq_fsm_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd1,
    S_PRE  = 3'd2,
    S_WAIT = 3'd3,
    S_POST = 3'd4,
    S_DECR = 3'd5
  } state_t;

`ifdef FMC_ADC_THRES_TRIG_EN
  localparam logic [7:0] TRIG_EN_MASK = 8'hF7;
`else
  localparam logic [7:0] TRIG_EN_MASK = 8'h07;
`endif

  state_t                     state_q, state_d, first_st;
  logic [31:0]                cnt_q, cnt_d;
  logic [15:0]                rem_q, rem_d;
  logic                       trig_q, trig_d, end_q, end_d;
  logic                       ack_q, ext_q;
  logic [31:0]                rdata_q, rdata_d;
  logic [15:0]                shots_q;
  logic [31:0]                pre_q, post_q;
  logic [7:0]                 trig_en_q;
  logic                       wr_vld_q;
  logic [16*G_CHANNELS-1:0]   wr_data_q;
  logic [23:0]                wr_addr_q;
  logic                       acc, reg_wr, ctl_wr, stop, start_acc, sw_trig, trig_any, capture;
  logic [G_CHANNELS-1:0]      thr_hit;

  // A held strobe is accepted once; ack follows one cycle later.
  assign acc       = reg_stb_i & ~ack_q;
  assign reg_wr    = acc & reg_we_i;
  assign ctl_wr    = reg_wr && (reg_addr_i == 6'h00);
  assign stop      = ctl_wr & reg_wdata_i[1];
  assign start_acc = ctl_wr & reg_wdata_i[0] & ~reg_wdata_i[1] & (state_q == S_IDLE)
                     & (shots_q != 16'd0) & (post_q != 32'd0);
  assign sw_trig   = reg_wr && (reg_addr_i == 6'h0C);
  assign trig_any  = (trig_en_q[0] & ext_trig_i & ~ext_q) | (trig_en_q[1] & sw_trig)
                     | (trig_en_q[2] & time_trig_i) | (|thr_hit);
  assign capture   = smp_valid_i & ((state_q == S_PRE) | (state_q == S_WAIT) | (state_q == S_POST));
  assign first_st  = (pre_q == 32'd0) ? S_WAIT : S_PRE;

`ifdef FMC_ADC_THRES_TRIG_EN
  logic [31:0] thres_q [G_CHANNELS];

  for (genvar c = 0; c < G_CHANNELS; c++) begin : g_thr
    logic signed [17:0] smp_s, val_s, low_s;
    logic               armed_q, arm_c, fire_c;
    // 18-bit arithmetic keeps val-hyst exact for any val/hyst combination.
    assign smp_s = {{2{smp_data_i[16*c+15]}}, smp_data_i[16*c +: 16]};
    assign val_s = {{2{thres_q[c][15]}}, thres_q[c][15:0]};
    assign low_s = val_s - $signed({2'b00, thres_q[c][31:16]});
    assign arm_c  = smp_s < low_s;
    assign fire_c = armed_q & (smp_s >= val_s);
    assign thr_hit[c] = smp_valid_i & fire_c & trig_en_q[4+c];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        armed_q <= 1'b0;
      end else if (smp_valid_i) begin
        if (fire_c)     armed_q <= 1'b0;
        else if (arm_c) armed_q <= 1'b1;
      end
    end
  end
`else
  assign thr_hit = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shots_q   <= '0;
      pre_q     <= '0;
      post_q    <= '0;
      trig_en_q <= '0;
`ifdef FMC_ADC_THRES_TRIG_EN
      for (int c = 0; c < G_CHANNELS; c++) thres_q[c] <= '0;
`endif
    end else if (reg_wr) begin
      case (reg_addr_i)
        6'h08: trig_en_q <= reg_wdata_i[7:0] & TRIG_EN_MASK;
        6'h10: shots_q   <= reg_wdata_i[15:0];
        6'h14: pre_q     <= reg_wdata_i;
        6'h18: post_q    <= reg_wdata_i;
`ifdef FMC_ADC_THRES_TRIG_EN
        6'h20: thres_q[0] <= reg_wdata_i;
        6'h24: thres_q[1] <= reg_wdata_i;
        6'h28: thres_q[2] <= reg_wdata_i;
        6'h2C: thres_q[3] <= reg_wdata_i;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    case (reg_addr_i)
      6'h04: rdata_d = {29'd0, state_q};
      6'h08: rdata_d = {24'd0, trig_en_q};
      6'h10: rdata_d = {16'd0, shots_q};
      6'h14: rdata_d = pre_q;
      6'h18: rdata_d = post_q;
      6'h1C: rdata_d = {16'd0, rem_q};
`ifdef FMC_ADC_THRES_TRIG_EN
      6'h20: rdata_d = thres_q[0];
      6'h24: rdata_d = thres_q[1];
      6'h28: rdata_d = thres_q[2];
      6'h2C: rdata_d = thres_q[3];
`endif
      default: rdata_d = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    trig_d  = 1'b0;
    end_d   = 1'b0;
    case (state_q)
      S_IDLE: if (start_acc) begin
        state_d = first_st;
        cnt_d   = '0;
        rem_d   = shots_q;
      end
      S_PRE: if (smp_valid_i) begin
        if (cnt_q + 32'd1 >= pre_q) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      // The trigger-cycle sample is already the first post-trigger sample.
      S_WAIT: if (trig_any) begin
        trig_d = 1'b1;
        if (smp_valid_i && post_q == 32'd1) begin
          state_d = S_DECR;
          cnt_d   = '0;
        end else begin
          state_d = S_POST;
          cnt_d   = {31'd0, smp_valid_i};
        end
      end
      S_POST: if (smp_valid_i) begin
        if (cnt_q + 32'd1 >= post_q) begin
          state_d = S_DECR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DECR: begin
        rem_d = rem_q - 16'd1;
        cnt_d = '0;
        if (rem_q <= 16'd1) begin
          state_d = S_IDLE;
          end_d   = 1'b1;
        end else begin
          state_d = first_st;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      trig_d  = 1'b0;
      end_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      trig_q    <= 1'b0;
      end_q     <= 1'b0;
      ext_q     <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      wr_vld_q  <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      trig_q   <= trig_d;
      end_q    <= end_d;
      ext_q    <= ext_trig_i;
      ack_q    <= acc;
      rdata_q  <= (acc & ~reg_we_i) ? rdata_d : 32'd0;
      wr_vld_q <= capture;
      if (capture) wr_data_q <= smp_data_i;
      // Address presented with a write is that write's slot; it advances afterwards.
      if (start_acc)     wr_addr_q <= '0;
      else if (wr_vld_q) wr_addr_q <= wr_addr_q + 24'd1;
    end
  end

  assign reg_ack_o       = ack_q;
  assign reg_rdata_o     = rdata_q;
  assign wr_valid_o      = wr_vld_q;
  assign wr_data_o       = wr_data_q;
  assign wr_addr_o       = wr_addr_q;
  assign trig_o          = trig_q;
  assign acq_end_o       = end_q;
  assign acq_fsm_state_o = state_q;

endmodule

// File: tb/tb_spec_top_fmc_adc_100ms.sv
// Bench for spec_top_fmc_adc_100ms: directed and randomized acquisitions checked against a sample scoreboard.
module tb_spec_top_fmc_adc_100ms;
  logic        clk = 1'b0;
  logic        rst_i, reg_we_i, reg_stb_i, reg_ack_o;
  logic [5:0]  reg_addr_i;
  logic [31:0] reg_wdata_i, reg_rdata_o;
  logic        smp_valid_i, ext_trig_i, time_trig_i;
  logic [63:0] smp_data_i, wr_data_o;
  logic        wr_valid_o, trig_o, acq_end_o;
  logic [23:0] wr_addr_o;
  logic [2:0]  acq_fsm_state_o;

  localparam logic [5:0] A_CTL = 6'h00, A_STA = 6'h04, A_TEN = 6'h08, A_SWT = 6'h0C, A_SHOTS = 6'h10,
                         A_PRE = 6'h14, A_POST = 6'h18, A_REM = 6'h1C, A_TH1 = 6'h20;

  int n_assert = 0, n_fail = 0, n_wr = 0, n_trig = 0, n_end = 0, wr_base = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  spec_top_fmc_adc_100ms dut (
    .clk_i(clk), .rst_i(rst_i), .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
    .reg_we_i(reg_we_i), .reg_stb_i(reg_stb_i), .reg_ack_o(reg_ack_o), .reg_rdata_o(reg_rdata_o),
    .smp_valid_i(smp_valid_i), .smp_data_i(smp_data_i), .ext_trig_i(ext_trig_i),
    .time_trig_i(time_trig_i), .wr_valid_o(wr_valid_o), .wr_data_o(wr_data_o),
    .wr_addr_o(wr_addr_o), .trig_o(trig_o), .acq_end_o(acq_end_o),
    .acq_fsm_state_o(acq_fsm_state_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the next sample the bench expects, in address order.
  always @(negedge clk) begin
    if (trig_o) n_trig++;
    if (acq_end_o) n_end++;
    if (wr_valid_o) begin
      chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("wr_data", wr_data_o, exp_q.pop_front());
      chk("wr_addr", 64'(wr_addr_o), 64'(24'(n_wr - wr_base)));
      n_wr++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reg_wr(input logic [5:0] a, input logic [31:0] d);
    reg_addr_i = a; reg_wdata_i = d; reg_we_i = 1'b1; reg_stb_i = 1'b1;
    tick();
    reg_stb_i = 1'b0; reg_we_i = 1'b0;
    tick();
  endtask

  task automatic reg_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    reg_addr_i = a; reg_we_i = 1'b0; reg_stb_i = 1'b1;
    tick();
    chk({tag, "_ack"}, 64'(reg_ack_o), 64'd1);
    chk(tag, 64'(reg_rdata_o), 64'(exp));
    reg_stb_i = 1'b0;
    tick();
  endtask

  task automatic cfg(input int pre, input int post, input int shots, input logic [7:0] en);
    reg_wr(A_SHOTS, 32'(shots)); reg_wr(A_PRE, 32'(pre)); reg_wr(A_POST, 32'(post)); reg_wr(A_TEN, {24'd0, en});
  endtask

  task automatic start();
    wr_base = n_wr;
    reg_wr(A_CTL, 32'h1);
  endtask

  task automatic sample(input logic [63:0] d);
    smp_valid_i = 1'b1; smp_data_i = d; exp_q.push_back(d);
    tick();
    smp_valid_i = 1'b0;
  endtask

  task automatic samples(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(maxgap)) tick();
      sample({$urandom, $urandom});
    end
  endtask

  // src: 0 = software write, 1 = external rising edge, 2 = time match
  task automatic fire(input int src);
    case (src)
      0: begin reg_addr_i = A_SWT; reg_wdata_i = 32'h0; reg_we_i = 1'b1; reg_stb_i = 1'b1; end
      1: ext_trig_i = 1'b1;
      default: time_trig_i = 1'b1;
    endcase
    tick();
    chk("trig_pulse", 64'(trig_o), 64'd1);
    chk("state_post", 64'(acq_fsm_state_o), 64'd4);
    reg_stb_i = 1'b0; reg_we_i = 1'b0; ext_trig_i = 1'b0; time_trig_i = 1'b0;
    tick();
  endtask

  initial begin
    int t0, e0, w0, pre, post, shots, fired_v;
    logic armed;
    rst_i = 1'b1; reg_addr_i = '0; reg_wdata_i = '0; reg_we_i = 1'b0; reg_stb_i = 1'b0;
    smp_valid_i = 1'b0; smp_data_i = '0; ext_trig_i = 1'b0; time_trig_i = 1'b0;
    repeat (3) tick();
    chk("rst_state", 64'(acq_fsm_state_o), 64'd1);
    chk("rst_wr_valid", 64'(wr_valid_o), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr_o), 64'd0);
    chk("rst_trig", 64'(trig_o), 64'd0);
    chk("rst_end", 64'(acq_end_o), 64'd0);
    chk("rst_ack", 64'(reg_ack_o), 64'd0);
    rst_i = 1'b0;
    tick();

    reg_chk("sta_idle", A_STA, 32'd1);
    reg_wr(A_SHOTS, 32'hABCD_1234); reg_chk("shots_rb", A_SHOTS, 32'h1234);
    reg_wr(A_PRE, 32'hDEAD_BEEF);   reg_chk("pre_rb", A_PRE, 32'hDEAD_BEEF);
    reg_wr(6'h30, 32'hFFFF_FFFF);   reg_chk("unmapped_rd", 6'h30, 32'd0);
    reg_wr(6'h3C, 32'h5555_5555);   reg_chk("shots_keep", A_SHOTS, 32'h1234);
    reg_wr(A_TEN, 32'hFF);
    reg_wr(A_TH1, 32'h0100_0300);
`ifdef FMC_ADC_THRES_TRIG_EN
    reg_chk("trig_en_rb", A_TEN, 32'hF7);
    reg_chk("thres_rb", A_TH1, 32'h0100_0300);
`else
    reg_chk("trig_en_rb", A_TEN, 32'h07);
    reg_chk("thres_rb", A_TH1, 32'h0);
`endif

    // Start with zero shots is refused
    cfg(0, 4, 0, 8'h02); start();
    chk("shots0_state", 64'(acq_fsm_state_o), 64'd1);

    // Single shot, no pre-trigger, one post sample
    cfg(0, 1, 1, 8'h02); t0 = n_trig; e0 = n_end; start();
    chk("pre0_wait", 64'(acq_fsm_state_o), 64'd3);
    fire(0); sample(64'h0123_4567_89AB_CDEF); repeat (3) tick();
    chk("s1_writes", 64'(n_wr - wr_base), 64'd1);
    chk("s1_trigs", 64'(n_trig - t0), 64'd1);
    chk("s1_end", 64'(n_end - e0), 64'd1);
    chk("s1_state", 64'(acq_fsm_state_o), 64'd1);

    // Three shots, software triggers 1 us apart, SHOTS_REM counting down
    cfg(0, 2, 3, 8'h02); t0 = n_trig; e0 = n_end; start();
    reg_chk("rem_load", A_REM, 32'd3);
    for (int k = 0; k < 3; k++) begin
      repeat (100) tick();
      fire(0); samples(2, 0); repeat (3) tick();
      reg_chk("rem_dec", A_REM, 32'(2 - k));
    end
    chk("s3_trigs", 64'(n_trig - t0), 64'd3);
    chk("s3_end", 64'(n_end - e0), 64'd1);
    chk("s3_state", 64'(acq_fsm_state_o), 64'd1);

    // Two shots of 16 pre + 128 post, 100 ns external trigger pulses
    cfg(16, 128, 2, 8'h05); t0 = n_trig; e0 = n_end; start();
    for (int k = 0; k < 2; k++) begin
      samples(16, 0); tick();
      ext_trig_i = 1'b1; tick();
      chk("ext_trig", 64'(trig_o), 64'd1);
      repeat (9) tick();
      ext_trig_i = 1'b0;
      samples(128, 0); repeat (3) tick();
    end
    chk("ext_writes", 64'(n_wr - wr_base), 64'd288);
    chk("ext_addr", 64'(wr_addr_o), 64'd288);
    chk("ext_trigs", 64'(n_trig - t0), 64'd2);
    chk("ext_end", 64'(n_end - e0), 64'd1);

    // Randomized shapes and trigger sources
    for (int it = 0; it < 5; it++) begin
      pre = $urandom_range(8); post = $urandom_range(10, 1); shots = $urandom_range(3, 1);
      cfg(pre, post, shots, 8'h07); t0 = n_trig; e0 = n_end; start();
      for (int s = 0; s < shots; s++) begin
        samples(pre, 2); tick();
        fire($urandom_range(2));
        samples(post, 2); repeat (3) tick();
      end
      chk("rnd_trigs", 64'(n_trig - t0), 64'(shots));
      chk("rnd_end", 64'(n_end - e0), 64'd1);
      chk("rnd_state", 64'(acq_fsm_state_o), 64'd1);
      chk("rnd_addr", 64'(wr_addr_o), 64'((pre + post) * shots));
      chk("rnd_drained", 64'(exp_q.size()), 64'd0);
    end

    // Disabled source ignored, stop in WAIT_TRIG gives no end pulse
    cfg(0, 4, 1, 8'h02); t0 = n_trig; e0 = n_end; start();
    ext_trig_i = 1'b1; tick(); ext_trig_i = 1'b0; tick();
    chk("dis_ext_state", 64'(acq_fsm_state_o), 64'd3);
    chk("dis_ext_trigs", 64'(n_trig - t0), 64'd0);
    reg_addr_i = A_CTL; reg_wdata_i = 32'h2; reg_we_i = 1'b1; reg_stb_i = 1'b1;
    tick();
    chk("stop_state", 64'(acq_fsm_state_o), 64'd1);
    reg_stb_i = 1'b0; reg_we_i = 1'b0;
    repeat (3) tick();
    chk("stop_no_end", 64'(n_end - e0), 64'd0);

`ifdef FMC_ADC_THRES_TRIG_EN
    // ch1 threshold: arms below val-hyst, fires at first ramp sample reaching val
    reg_wr(A_TH1, 32'h0100_0300);
    cfg(0, 1, 1, 8'h12); t0 = n_trig; e0 = n_end; start();
    armed = 1'b0; fired_v = -1;
    for (int v = 0; v <= 1000; v += 8) begin
      sample({48'd0, 16'(v)});
      if (armed && v >= 'h300) begin
        fired_v = v;
        chk("thr_fire", 64'(trig_o), 64'd1);
        break;
      end
      if (v < 'h300 - 'h100) armed = 1'b1;
    end
    repeat (3) tick();
    chk("thr_trigs", 64'(n_trig - t0), 64'(fired_v >= 0));
    chk("thr_end", 64'(n_end - e0), 64'd1);
    chk("thr_drained", 64'(exp_q.size()), 64'd0);
    cfg(0, 1, 1, 8'h02); t0 = n_trig; start();
    for (int v = 0; v <= 1000; v += 8) sample({48'd0, 16'(v)});
    tick();
    chk("thr_off_trigs", 64'(n_trig - t0), 64'd0);
    chk("thr_off_state", 64'(acq_fsm_state_o), 64'd3);
    reg_wr(A_CTL, 32'h2); repeat (2) tick();
    chk("thr_off_drained", 64'(exp_q.size()), 64'd0);
`endif

    // Reset in the middle of POST_TRIG
    cfg(0, 50, 1, 8'h02); e0 = n_end; start();
    fire(0); samples(3, 0); repeat (2) tick();
    rst_i = 1'b1; tick();
    chk("rst_mid_state", 64'(acq_fsm_state_o), 64'd1);
    chk("rst_mid_addr", 64'(wr_addr_o), 64'd0);
    rst_i = 1'b0; wr_base = n_wr; tick();
    reg_chk("rst_shots", A_SHOTS, 32'd0);
    reg_chk("rst_post", A_POST, 32'd0);
    reg_chk("rst_ten", A_TEN, 32'd0);
    reg_chk("rst_rem", A_REM, 32'd0);
    chk("rst_no_end", 64'(n_end - e0), 64'd0);
    chk("rst_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
